// File: rtl/approx_mul_pkg.sv
// Shared widths, FSM state encoding and host-side normalisation constant
// for the approximate-multiplier error-metric accumulator.
package approx_mul_pkg;

    localparam int IN_W  = 8;
    localparam int OUT_W = 16;
    localparam int CNT_W = 20;
    localparam int ACC_W = 36;

    // MNED = MED / (255*255); the divide happens on the host, not in hardware.
    localparam int MNED_NORM = 65025;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/approx_mul_error_accum_err_dist_stage.sv
// Two-stage datapath: S1 captures the operands and the approximate product,
// S2 captures the signed error distance (exact - approx) and its magnitude.
// Each stage carries its own valid bit; data registers only load on valid.
module err_dist_stage
    import approx_mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic [IN_W-1:0]  i_a,
    input  logic [IN_W-1:0]  i_b,
    input  logic [OUT_W-1:0] i_p,
    output logic             o_s1_valid,
    output logic             o_valid,
    output logic [OUT_W:0]   o_diff,
    output logic [OUT_W-1:0] o_absd
);

    logic             r_s1_valid;
    logic [IN_W-1:0]  r_s1_a;
    logic [IN_W-1:0]  r_s1_b;
    logic [OUT_W-1:0] r_s1_p;
    logic             r_s2_valid;
    logic [OUT_W:0]   r_s2_diff;
    logic [OUT_W-1:0] r_s2_absd;

    logic [OUT_W-1:0] w_exact;
    logic [OUT_W:0]   w_diff;
    logic [OUT_W-1:0] w_absd;

    // Unsigned 8x8 product never exceeds 16 bits, so no truncation here.
    assign w_exact = OUT_W'(r_s1_a) * OUT_W'(r_s1_b);
    // One extra bit keeps the subtraction exact in two's complement.
    assign w_diff  = {1'b0, w_exact} - {1'b0, r_s1_p};
    // |diff| <= 65535 always fits in OUT_W bits.
    assign w_absd  = w_diff[OUT_W] ? (~w_diff[OUT_W-1:0] + 1'b1) : w_diff[OUT_W-1:0];

    // S1: register the incoming sample when the top accepts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_p     <= '0;
        end else begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_a <= i_a;
                r_s1_b <= i_b;
                r_s1_p <= i_p;
            end
        end
    end

    // S2: register the error distance of the sample held in S1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_diff  <= '0;
            r_s2_absd  <= '0;
        end else begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_diff <= w_diff;
                r_s2_absd <= w_absd;
            end
        end
    end

    assign o_s1_valid = r_s1_valid;
    assign o_valid    = r_s2_valid;
    assign o_diff     = r_s2_diff;
    assign o_absd     = r_s2_absd;

endmodule

// File: rtl/approx_mul_error_accum.sv
// Error-metric accumulator for an 8x8 approximate multiplier: run FSM,
// accept counter and the saturating metric accumulators.
//
// Handshake: a sample transfers on a rising edge where in_valid and
// in_ready are both high. in_ready is high only in RUN and does not depend
// on in_valid; the sender must hold a/b/p_apprx stable while in_valid is
// high and not yet accepted.
module approx_mul_error_accum
    import approx_mul_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] n_samples,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  a,
    input  logic [IN_W-1:0]  b,
    input  logic [OUT_W-1:0] p_apprx,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] sample_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [ACC_W:0]   sum_ed,
    output logic [ACC_W-1:0] sum_ed_abs,
    output logic [OUT_W-1:0] max_ed,
    output state_t           dbg_state
);

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_accepted;
    logic [CNT_W-1:0] r_sample_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [ACC_W:0]   r_sum_ed;
    logic [ACC_W-1:0] r_sum_abs;
    logic [OUT_W-1:0] r_max_ed;

    logic             w_hs;
    logic             w_last;
    logic             w_start_ok;
    logic             w_s1_valid;
    logic             w_s2_valid;
    logic [OUT_W:0]   w_s2_diff;
    logic [OUT_W-1:0] w_s2_absd;
    logic             w_acc_en;
    logic [ACC_W+1:0] w_sum_ext;
    logic [ACC_W:0]   w_abs_ext;

    assign in_ready   = (r_state == RUN);
    assign busy       = (r_state == RUN) || (r_state == DRAIN);
    assign done       = (r_state == DONE);
    assign dbg_state  = r_state;

    assign w_hs       = in_valid && in_ready;
    assign w_last     = w_hs && ((r_accepted + CNT_W'(1)) == r_target);
    assign w_start_ok = start && ((r_state == IDLE) || (r_state == DONE));
    assign w_acc_en   = w_s2_valid && busy;

    err_dist_stage u_stage (
        .clk        (clk),
        .rst        (rst),
        .i_valid    (w_hs),
        .i_a        (a),
        .i_b        (b),
        .i_p        (p_apprx),
        .o_s1_valid (w_s1_valid),
        .o_valid    (w_s2_valid),
        .o_diff     (w_s2_diff),
        .o_absd     (w_s2_absd)
    );

    // Next-state logic. DRAIN leaves once S1 is empty: the sample in S2 is
    // folded into the accumulators on that same edge, so done and the final
    // totals appear together two cycles after the last accept.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE, DONE: begin
                if (start) begin
                    w_next = (n_samples == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!w_s1_valid) begin
                    w_next = DONE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Run length and accept counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_target   <= '0;
            r_accepted <= '0;
        end else if (w_start_ok) begin
            r_target   <= n_samples;
            r_accepted <= '0;
        end else if (w_hs) begin
            r_accepted <= r_accepted + CNT_W'(1);
        end
    end

    // Wide sums with one guard bit for saturation detection.
    assign w_sum_ext = {r_sum_ed[ACC_W], r_sum_ed}
                     + {{(ACC_W + 1 - OUT_W){w_s2_diff[OUT_W]}}, w_s2_diff};
    assign w_abs_ext = {1'b0, r_sum_abs} + {{(ACC_W + 1 - OUT_W){1'b0}}, w_s2_absd};

    // Metric accumulators: cleared on an accepted start, updated per S2 sample.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_sum_ed     <= '0;
            r_sum_abs    <= '0;
            r_max_ed     <= '0;
        end else if (w_start_ok) begin
            r_sample_cnt <= '0;
            r_err_cnt    <= '0;
            r_sum_ed     <= '0;
            r_sum_abs    <= '0;
            r_max_ed     <= '0;
        end else if (w_acc_en) begin
            r_sample_cnt <= r_sample_cnt + CNT_W'(1);
            if (w_s2_diff != '0) begin
                r_err_cnt <= r_err_cnt + CNT_W'(1);
            end
            // Signed overflow shows as disagreement between the top two bits.
            if (w_sum_ext[ACC_W+1] != w_sum_ext[ACC_W]) begin
                r_sum_ed <= w_sum_ext[ACC_W+1] ? {1'b1, {ACC_W{1'b0}}} : {1'b0, {ACC_W{1'b1}}};
            end else begin
                r_sum_ed <= w_sum_ext[ACC_W:0];
            end
            r_sum_abs <= w_abs_ext[ACC_W] ? {ACC_W{1'b1}} : w_abs_ext[ACC_W-1:0];
            if (w_s2_absd > r_max_ed) begin
                r_max_ed <= w_s2_absd;
            end
        end
    end

    assign sample_cnt = r_sample_cnt;
    assign err_cnt    = r_err_cnt;
    assign sum_ed     = r_sum_ed;
    assign sum_ed_abs = r_sum_abs;
    assign max_ed     = r_max_ed;

endmodule

// File: doc/approx_mul_error_accum.md
Name: approx_mul_error_accum

Overview:
- Synthesizable error-metric accumulator placed directly downstream of the 8x8 approximate multiplier under evaluation.
- Each accepted sample carries operands A, B and the approximate product. The block computes the exact product internally, then accumulates:
  - error count
  - signed error-distance sum
  - absolute error-distance sum
  - maximum absolute error distance
  - sample count
- Software derives ER, MED and MNED from the final totals. Replaces the slow simulation-only metric loop for on-board or emulation runs.

Parameters:
- IN_W, 8, operand width.
- OUT_W, 16, product width (2*IN_W).
- CNT_W, 20, sample counter width (supports 1,000,000 samples).
- ACC_W, 36, unsigned accumulator width (OUT_W+CNT_W).

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-high reset.
- start  in  1  one-cycle pulse; begins a run (honoured in IDLE/DONE only).
- n_samples  in  CNT_W  run length; sampled on accepted start.
- in_valid  in  1  sample present.
- in_ready  out  1  block accepts sample this cycle.
- a  in  IN_W  operand A.
- b  in  IN_W  operand B.
- p_apprx  in  OUT_W  approximate product from the multiplier.
- busy  out  1  high in RUN and DRAIN.
- done  out  1  high in DONE; results stable.
- sample_cnt  out  CNT_W  samples accumulated.
- err_cnt  out  CNT_W  samples with exact != apprx.
- sum_ed  out  ACC_W+1  signed sum of (exact - apprx), two's complement.
- sum_ed_abs  out  ACC_W  sum of |exact - apprx|.
- max_ed  out  OUT_W  maximum |exact - apprx|.

Behaviour:
- Reset (async, any state, including mid-run):
  - State goes to IDLE.
  - All outputs and accumulators go to 0: in_ready=0, busy=0, done=0.
  - Pipeline valid bits are cleared; in-flight samples are discarded.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - On start: load target=n_samples, clear all accumulators and the accept counter.
  - If n_samples=0, go to DONE; otherwise go to RUN.
- RUN:
  - in_ready=1. A handshake is in_valid & in_ready.
  - Each handshake pushes the sample into the pipeline and increments the accept counter.
  - The handshake that makes accepted==target moves the FSM to DRAIN on the next edge. in_ready=0 from that point.
  - start is ignored.
- DRAIN:
  - in_ready=0.
  - Stays until both pipeline stages are empty (exactly 2 cycles after the last accept), then goes to DONE.
- DONE:
  - done=1 and results are held.
  - start clears the accumulators and restarts, as in IDLE.
- Pipeline: 2 stages, each stage gated by its own valid bit.
  - S1: register a, b, p_apprx; exact = a*b, full OUT_W, unsigned.
  - S2: diff = exact - apprx, OUT_W+1 signed; absd = |diff|.
  - Accumulation:
    - err_cnt += (diff != 0)
    - sum_ed += sign-extended diff
    - sum_ed_abs += absd
    - max_ed = max(max_ed, absd)
    - sample_cnt += 1
  - Outputs reflect a sample 2 cycles after its handshake. Bubbles (in_valid=0) do not change the accumulators.
- Width and overflow:
  - sum_ed_abs saturates at all-ones and does not wrap.
  - sum_ed saturates at the signed max/min.
  - Counters cannot overflow because target < 2^CNT_W.
- Accumulators are updated only in RUN/DRAIN. The values in DONE are final.

Decomposition:
- Package approx_mul_pkg holds:
  - width constants IN_W, OUT_W, CNT_W, ACC_W
  - the state enum (IDLE, RUN, DRAIN, DONE)
  - the MNED normalisation constant 65025 (255*255), for use by the host-side scoreboard
- Sub-module err_dist_stage: the S1/S2 datapath producing a valid-tagged diff/absd. The top holds the FSM and the accumulators.

Test Plan:
- Reset then start with n_samples=1; a=255, b=255, p_apprx=65000 → done after handshake+2 cycles; err_cnt=1, sum_ed=25, sum_ed_abs=25, max_ed=25, sample_cnt=1.
- n_samples=3; samples (3,5,17), (4,4,16), (10,10,90) → err_cnt=2, sum_ed=-2+0+10=8, sum_ed_abs=12, max_ed=10.
- n_samples=4 with in_valid gaps (valid 1,0,0,1,1,0,1) → sample_cnt=4 exactly; in_ready drops after the 4th accept; extra valid samples are ignored.
- n_samples=0 → DONE one cycle after start; all results 0; in_ready never asserts.
- Assert rst after 2 of 5 samples → all outputs 0 and state IDLE immediately; a new start with 1 exact-match sample (7,9,63) gives err_cnt=0, sample_cnt=1.
- start pulse during RUN → ignored; a start in DONE clears the results and begins a new run.
